// File: rtl/p6_pkg.sv
// p6_pkg -- shared definitions for the p6 memory arbiter.
//
// Contents:
//   state_t             arbiter FSM encoding (IDLE, ACCESS, RESP)
//   GNT_NONE/CPU/LD     one-hot grant encodings, bit order {ld, cpu}
//   RR_CPU/RR_LD        encoding of the "last granted" requester used by
//                       the round-robin arbiter
package p6_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_CPU  = 2'b01;
  localparam logic [1:0] GNT_LD   = 2'b10;

  localparam logic RR_CPU = 1'b0;
  localparam logic RR_LD  = 1'b1;

endpackage

// File: rtl/p6_arb_pick.sv
// p6_arb_pick -- combinational winner select for the p6 memory arbiter.
//
// Ports:
//   cpu_req  in   CPU request pending
//   ld_req   in   loader request pending
//   rr_last  in   requester granted last (RR_CPU / RR_LD); on contention the
//                 other requester wins
//   grant    out  one-hot {ld, cpu} winner, GNT_NONE when nobody requests
module p6_arb_pick
  import p6_pkg::*;
(
  input  logic       cpu_req,
  input  logic       ld_req,
  input  logic       rr_last,
  output logic [1:0] grant
);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    grant = GNT_NONE;
    if (cpu_req && ld_req) begin
      grant = (rr_last == RR_LD) ? GNT_CPU : GNT_LD;
    end else if (cpu_req) begin
      grant = GNT_CPU;
    end else if (ld_req) begin
      grant = GNT_LD;
    end
  end

endmodule

// File: rtl/p6_mem_arbiter.sv
// p6_mem_arbiter -- two-master arbiter in front of one single-port RAM.
//
// A CPU and a program loader share a synchronous-read RAM. Each transaction
// takes exactly three cycles: IDLE (request sampled and latched), ACCESS
// (RAM driven, write strobe for writes), RESP (one-cycle ack, read data).
//
// Configuration macro:
//   P6_ARB_RR_EN  defined   -> round-robin on contention (rr_last register)
//                 undefined -> fixed priority, loader always wins
//
// Parameters:
//   ADDR_W  RAM address width
//   DATA_W  RAM data width
//
// Ports:
//   clk                          rising-edge clock
//   reset                        synchronous, active-high reset
//   cpu_req/we/addr/wdata        CPU request channel
//   cpu_ack, cpu_rdata           CPU response channel
//   ld_req/we/addr/wdata         loader request channel
//   ld_ack, ld_rdata             loader response channel
//   ram_addr, ram_we, ram_wdata  RAM drive
//   ram_rdata                    RAM read data, valid one clock after address
//   busy                         high while not IDLE
//   grant                        one-hot {ld, cpu} owner of current transaction
module p6_mem_arbiter
  import p6_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic [1:0]        grant
);

  state_t              state_q, state_d;
  logic [1:0]          grant_q;
  logic [1:0]          pick_grant;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic [DATA_W-1:0]   ld_rdata_q;
  logic                rr_last;
  logic                take;

`ifdef P6_ARB_RR_EN
  logic rr_last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last_q <= RR_LD;
    end else if (take) begin
      rr_last_q <= (pick_grant == GNT_LD) ? RR_LD : RR_CPU;
    end
  end

  assign rr_last = rr_last_q;
`else
  // Fixed priority is the round-robin picker told that the CPU always went
  // last, so the loader wins every contention.
  assign rr_last = RR_CPU;
`endif

  p6_arb_pick u_pick (
    .cpu_req (cpu_req),
    .ld_req  (ld_req),
    .rr_last (rr_last),
    .grant   (pick_grant)
  );

  assign take = (state_q == IDLE) && (pick_grant != GNT_NONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (take) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= GNT_NONE;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        grant_q <= pick_grant;
        if (pick_grant == GNT_LD) begin
          lat_we    <= ld_we;
          lat_addr  <= ld_addr;
          lat_wdata <= ld_wdata;
        end else begin
          lat_we    <= cpu_we;
          lat_addr  <= cpu_addr;
          lat_wdata <= cpu_wdata;
        end
      end
      if (state_q == RESP) begin
        grant_q <= GNT_NONE;
        if (!lat_we && grant_q == GNT_CPU) cpu_rdata_q <= ram_rdata;
        if (!lat_we && grant_q == GNT_LD)  ld_rdata_q  <= ram_rdata;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign grant     = grant_q;
  assign ram_addr  = lat_addr;
  assign ram_wdata = lat_wdata;
  // Gating with reset keeps a reset that lands on ACCESS from committing the
  // write at that same edge.
  assign ram_we    = (state_q == ACCESS) && lat_we && !reset;

  assign cpu_ack   = (state_q == RESP) && (grant_q == GNT_CPU);
  assign ld_ack    = (state_q == RESP) && (grant_q == GNT_LD);

  // Read data is visible during the ack cycle and held afterwards.
  assign cpu_rdata = (cpu_ack && !lat_we) ? ram_rdata : cpu_rdata_q;
  assign ld_rdata  = (ld_ack  && !lat_we) ? ram_rdata : ld_rdata_q;

endmodule

// File: doc/p6_mem_arbiter.md
P6_MEM_ARBITER -- requirements
Module: p6_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the RAM address width.
REQ-002 SHALL have parameter DATA_W, default 16, meaning the RAM data width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports cpu_req (input, 1), cpu_we (input, 1), cpu_addr (input, ADDR_W) and cpu_wdata (input, DATA_W): the CPU request channel.
REQ-006 SHALL have ports cpu_ack (output, 1) and cpu_rdata (output, DATA_W): the CPU response channel.
REQ-007 SHALL have ports ld_req (input, 1), ld_we (input, 1), ld_addr (input, ADDR_W) and ld_wdata (input, DATA_W): the loader (switch/KEY program-load) request channel.
REQ-008 SHALL have ports ld_ack (output, 1) and ld_rdata (output, DATA_W): the loader response channel.
REQ-009 SHALL have ports ram_addr (output, ADDR_W), ram_we (output, 1) and ram_wdata (output, DATA_W): the single-port RAM drive.
REQ-010 SHALL have port ram_rdata, input, DATA_W: RAM read data, valid one clock after the address is presented.
REQ-011 SHALL have ports busy (output, 1) and grant (output, 2): busy is high while not IDLE; grant is one-hot {ld, cpu} for the owner of the current transaction.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, ACCESS, RESP.
REQ-013 SHALL, in IDLE with any request pending, select a winner, latch its we/addr/wdata into internal registers, set grant, and move to ACCESS.
REQ-014 SHALL, in ACCESS, drive ram_addr and ram_wdata from the latched values, assert ram_we for exactly one cycle when the latched we=1, and move to RESP.
REQ-015 SHALL, in RESP, pulse the winner's ack high for exactly one cycle, drive its rdata from ram_rdata (reads only), and return to IDLE.
REQ-016 SHALL have a fixed latency: request sampled at edge N, RAM access in cycle N+1, ack in cycle N+2; throughput is at most one transaction per 3 cycles.
REQ-017 SHALL ignore changes on request inputs after latching; a requester holding req high after its ack is treated as a new request.
REQ-018 SHALL hold rdata outputs until that requester's next ack; write acks leave rdata unchanged.
REQ-019 SHALL, when cpu_req and ld_req are both high in IDLE, arbitrate per REQ-024/REQ-025.
REQ-020 SHALL keep ram_we=0 in all states other than ACCESS, and ram_addr at the last latched value.
REQ-021 SHALL never assert both acks in the same cycle, and never assert an ack without a preceding ACCESS.

Reset
REQ-022 SHALL, on reset=1 at a clock edge, force IDLE and set cpu_ack=0, ld_ack=0, ram_we=0, busy=0, grant=00, ram_addr=0, ram_wdata=0, cpu_rdata=0, ld_rdata=0 and rr_last=LD, regardless of the current state.
REQ-023 SHALL, on reset mid-transaction, abort with no ack and no RAM write issued after the reset edge.

Configuration
REQ-024 SHALL, with macro P6_ARB_RR_EN defined, use round-robin on contention: the requester not granted last wins, and rr_last updates on every grant.
REQ-025 SHALL, with P6_ARB_RR_EN undefined, use fixed priority on contention: the loader always wins, and no rr_last register exists.

Structure
REQ-026 SHALL place the FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2) and the grant encodings (GNT_CPU=2'b01, GNT_LD=2'b10) in shared package p6_pkg.
REQ-027 SHALL implement the winner-select logic as sub-module p6_arb_pick, with inputs cpu_req, ld_req and rr_last, and output a one-hot grant.

Verification
REQ-028 SHALL pass: ld write of 0x0155 to addr 0x10, then cpu read of addr 0x10 -> ram_we high for one cycle; cpu_ack 2 cycles after request; cpu_rdata=0x0155.
REQ-029 SHALL pass: cpu_req and ld_req both high in IDLE after reset -> with RR, cpu granted first, then ld; without RR, ld granted first.
REQ-030 SHALL pass: both requesters held high for 12 cycles -> with RR, grants alternate cpu/ld; 4 acks total, 2 each.
REQ-031 SHALL pass: reset asserted during ACCESS of a write to 0x20 -> no ack, busy=0 the next cycle, and addr 0x20 unchanged if reset coincides with ACCESS.
REQ-032 SHALL pass: cpu_addr changed from 0x05 to 0x06 during ACCESS -> the RAM is accessed at 0x05.
REQ-033 SHALL pass: cpu read of 0xFF (top address) -> correct data returned, with no address wrap or overflow.
